// File: rtl/kernel_apply.sv
// Applies a SIZE x SIZE weight kernel to a pixel window: sequential MAC, then a
// restoring divide by the kernel sum with round-half-up and 8-bit saturation.
//
// state | meaning
// IDLE  | waiting for a window; in_ready high
// MAC   | one tap per cycle, row-major, SIZE*SIZE cycles
// PREP  | range-check sum, load dividend acc + sum/2
// DIV   | one quotient bit per cycle, MSB first, ACC_W+1 cycles
// OUT   | result held until out_ready
module kernel_apply #(
  parameter int SIZE  = 5,
  parameter int ACC_W = 24
) (
  input  logic                         clk,
  input  logic                         n_rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [SIZE-1:0][SIZE-1:0][7:0] window,
  input  logic [SIZE-1:0][SIZE-1:0][7:0] kernel,
  input  logic [63:0]                  sum,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [7:0]                   pixel_out,
  output logic                         div_err
);

  localparam int TAPS    = SIZE * SIZE;
  localparam int CNT_MAX = (TAPS > ACC_W + 1) ? TAPS : ACC_W + 1;
  localparam int CW      = $clog2(CNT_MAX);

  typedef enum logic [2:0] {IDLE, MAC, PREP, DIV, OUT} state_t;

  state_t            state, state_nxt;
  logic [TAPS*8-1:0] win_q, ker_q;
  logic [63:0]       sum_q;
  logic [ACC_W-1:0]  acc_q;
  logic [CW-1:0]     cnt_q;
  logic [ACC_W:0]    num_q;
  logic [ACC_W-1:0]  quo_q;
  logic [ACC_W-1:0]  rem_q;

  logic              accept, last_tap, last_bit, sum_bad, ge;
  logic [15:0]       prod;
  logic [ACC_W:0]    trial, diff, quo_nxt;

  assign accept   = in_valid && in_ready;
  assign last_tap = (cnt_q == CW'(TAPS - 1));
  assign last_bit = (cnt_q == CW'(ACC_W));
  assign sum_bad  = (sum_q == 64'd0) || (sum_q[63:ACC_W] != '0);
  // Window and kernel registers shift down one byte per tap, so the current
  // tap is always in the low byte.
  assign prod     = win_q[7:0] * ker_q[7:0];
  assign trial    = {rem_q, num_q[ACC_W]};
  assign diff     = trial - {1'b0, sum_q[ACC_W-1:0]};
  assign ge       = (trial >= {1'b0, sum_q[ACC_W-1:0]});
  assign quo_nxt  = {quo_q, ge};

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = MAC;
      end
      MAC:  if (last_tap) state_nxt = PREP;
      PREP: state_nxt = sum_bad ? OUT : DIV;
      DIV:  if (last_bit) state_nxt = OUT;
      OUT: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      win_q     <= '0;
      ker_q     <= '0;
      sum_q     <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      num_q     <= '0;
      quo_q     <= '0;
      rem_q     <= '0;
      pixel_out <= '0;
      div_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          win_q <= window;
          ker_q <= kernel;
          sum_q <= sum;
          acc_q <= '0;
          cnt_q <= '0;
        end
        MAC: begin
          acc_q <= acc_q + ACC_W'(prod);
          win_q <= win_q >> 8;
          ker_q <= ker_q >> 8;
          cnt_q <= last_tap ? '0 : cnt_q + 1'b1;
        end
        PREP: begin
          if (sum_bad) begin
            div_err   <= 1'b1;
            pixel_out <= '0;
          end else begin
            num_q <= {1'b0, acc_q} + {1'b0, sum_q[ACC_W-1:0] >> 1};
          end
          rem_q <= '0;
          quo_q <= '0;
          cnt_q <= '0;
        end
        DIV: begin
          rem_q <= ge ? diff[ACC_W-1:0] : trial[ACC_W-1:0];
          num_q <= num_q << 1;
          quo_q <= quo_nxt[ACC_W-1:0];
          cnt_q <= cnt_q + 1'b1;
          if (last_bit) begin
            pixel_out <= (|quo_nxt[ACC_W:8]) ? 8'hFF : quo_nxt[7:0];
            div_err   <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_kernel_apply.sv
// Directed and randomized checks of kernel_apply against a plain-arithmetic
// weighted-average model (round-half-up, saturate, sum range check).
module tb_kernel_apply;
  localparam int SIZE    = 5;
  localparam int ACC_W   = 24;
  localparam int TAPS    = SIZE * SIZE;
  localparam int LAT_OK  = TAPS + ACC_W + 2;
  localparam int LAT_ERR = TAPS + 1;

  typedef logic [SIZE-1:0][SIZE-1:0][7:0] win_t;

  logic        clk = 1'b0;
  logic        n_rst = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b1;
  win_t        window = '0;
  win_t        kernel = '0;
  logic [63:0] sum = '0;
  logic        in_ready, out_valid, div_err;
  logic [7:0]  pixel_out;

  int vecs = 0;
  int miscompares = 0;

  kernel_apply #(.SIZE(SIZE), .ACC_W(ACC_W)) dut (
    .clk(clk), .n_rst(n_rst), .in_valid(in_valid), .in_ready(in_ready),
    .window(window), .kernel(kernel), .sum(sum), .out_valid(out_valid),
    .out_ready(out_ready), .pixel_out(pixel_out), .div_err(div_err)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vecs++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic void model(input win_t w, input win_t k, input logic [63:0] s,
                                output int pix, output int err);
    longint unsigned acc = 0;
    longint unsigned q;
    for (int r = 0; r < SIZE; r++)
      for (int c = 0; c < SIZE; c++)
        acc += longint'(w[r][c]) * longint'(k[r][c]);
    if (s == 64'd0 || s >= (64'd1 << ACC_W)) begin
      err = 1; pix = 0;
    end else begin
      q   = (acc + s / 2) / s;
      err = 0;
      pix = (q > 255) ? 255 : int'(q);
    end
  endfunction

  function automatic win_t fill(input int v);
    win_t w;
    for (int r = 0; r < SIZE; r++)
      for (int c = 0; c < SIZE; c++) w[r][c] = 8'(v);
    return w;
  endfunction

  function automatic win_t rand_win();
    win_t w;
    for (int r = 0; r < SIZE; r++)
      for (int c = 0; c < SIZE; c++) w[r][c] = 8'($urandom_range(0, 255));
    return w;
  endfunction

  function automatic logic [63:0] wsum(input win_t k);
    logic [63:0] s = 0;
    for (int r = 0; r < SIZE; r++)
      for (int c = 0; c < SIZE; c++) s += 64'(k[r][c]);
    return s;
  endfunction

  // One full transaction; hold > 0 keeps out_ready low for that many cycles in OUT.
  task automatic xfer(input string tag, input win_t w, input win_t k,
                      input logic [63:0] s, input int hold);
    int exp_pix, exp_err, lat;
    bit busy_ok = 1;
    bit stable_ok = 1;
    model(w, k, s, exp_pix, exp_err);
    @(negedge clk);
    chk({tag, ".in_ready_idle"}, 64'(in_ready), 64'd1);
    window = w; kernel = k; sum = s; in_valid = 1'b1;
    out_ready = (hold == 0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    window = rand_win(); kernel = rand_win(); sum = {$urandom, $urandom};
    lat = 0;
    while (1) begin
      @(negedge clk);
      if (out_valid === 1'b1 || lat > 200) break;
      if (in_ready !== 1'b0) busy_ok = 0;
      @(posedge clk);
      lat++;
    end
    chk({tag, ".latency"}, 64'(lat), 64'(exp_err ? LAT_ERR : LAT_OK));
    chk({tag, ".busy"}, 64'(busy_ok), 64'd1);
    chk({tag, ".pixel"}, 64'(pixel_out), 64'(exp_pix));
    chk({tag, ".div_err"}, 64'(div_err), 64'(exp_err));
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      in_valid = (i % 2 == 0);
      @(negedge clk);
      if (out_valid !== 1'b1 || pixel_out !== 8'(exp_pix) ||
          div_err !== 1'(exp_err) || in_ready !== 1'b0) stable_ok = 0;
    end
    if (hold > 0) begin
      in_valid = 1'b0;
      out_ready = 1'b1;
      chk({tag, ".backpressure_stable"}, 64'(stable_ok), 64'd1);
    end
    @(posedge clk);
    @(negedge clk);
    chk({tag, ".out_valid_after_hs"}, 64'(out_valid), 64'd0);
    chk({tag, ".in_ready_after_hs"}, 64'(in_ready), 64'd1);
  endtask

  initial begin
    win_t g, ctr;
    logic [63:0] gsum, s;
    int mode;

    #12;
    chk("reset.in_ready", 64'(in_ready), 64'd1);
    chk("reset.out_valid", 64'(out_valid), 64'd0);
    chk("reset.pixel_out", 64'(pixel_out), 64'd0);
    chk("reset.div_err", 64'(div_err), 64'd0);
    @(negedge clk);
    n_rst = 1'b1;

    xfer("uniform100", fill(100), fill(1), 64'd25, 0);

    for (int r = 0; r < SIZE; r++)
      for (int c = 0; c < SIZE; c++)
        g[r][c] = 8'(int'(255.0 * $exp(-real'((r - 2) * (r - 2) + (c - 2) * (c - 2)) / 8.0) + 0.5));
    gsum = wsum(g);
    xfer("gauss_flat200", fill(200), g, gsum, 0);
    ctr = fill(0); ctr[2][2] = 8'd255;
    xfer("gauss_centre", ctr, g, gsum, 0);

    ctr = fill(0); ctr[2][2] = 8'd1;
    g = fill(0); g[2][2] = 8'd3;
    xfer("round_3_over_2", g, ctr, 64'd2, 0);
    xfer("round_1_over_2", ctr, ctr, 64'd2, 0);

    xfer("saturate", fill(255), fill(255), 64'd1, 0);
    xfer("sum_zero", fill(100), fill(1), 64'd0, 0);
    xfer("sum_2p24", fill(100), fill(1), 64'd1 << 24, 10);
    xfer("backpressure", rand_win(), fill(1), 64'd25, 10);

    for (int i = 0; i < 20; i++) begin
      g = rand_win();
      mode = $urandom_range(0, 3);
      case (mode)
        0: s = wsum(g);
        1: s = 64'($urandom_range(1, 255));
        2: s = 64'($urandom & 32'h00FF_FFFF);
        default: s = {32'h0, $urandom};
      endcase
      xfer($sformatf("rand%0d", i), rand_win(), g, s, (i % 5 == 4) ? 3 : 0);
    end

    // Abort in the middle of the divide.
    @(negedge clk);
    window = fill(37); kernel = fill(9); sum = 64'd7; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (39) @(posedge clk);
    #2;
    n_rst = 1'b0;
    #1;
    chk("abort.out_valid", 64'(out_valid), 64'd0);
    chk("abort.in_ready", 64'(in_ready), 64'd1);
    chk("abort.pixel_out", 64'(pixel_out), 64'd0);
    @(negedge clk);
    n_rst = 1'b1;
    xfer("after_abort", fill(100), fill(1), 64'd25, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, miscompares);
    $finish;
  end
endmodule
